// File: rtl/warmboot_pkg.sv
// warmboot_pkg: shared constants and FSM state encoding for the warm-boot sequencer.
package warmboot_pkg;
    localparam int SLOT_W = 4;
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_DEBOUNCE  = 3'd1;
    localparam state_t S_ASSERT    = 3'd2;
    localparam state_t S_REQUEST   = 3'd3;
    localparam state_t S_WAIT_DONE = 3'd4;
    localparam state_t S_RELEASE   = 3'd5;
    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/warmboot_sync.sv
// warmboot_sync: N-stage async-reset single-bit synchroniser.
module warmboot_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_sync;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_sync <= '0;
        else       r_sync <= {r_sync[STAGES-2:0], i_d};
    end
    assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/warmboot_sequencer.sv
// warmboot_sequencer: qualifies the fabric BOOT trigger, holds the fabric in reset,
// hands the slot to the config controller via req/ack and releases after completion.
module warmboot_sequencer
    import warmboot_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RESET_CYCLES    = 16,
    parameter int RELEASE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES  = 65535,
    parameter int NUM_SLOTS       = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BOOT,
    input  logic [SLOT_W-1:0] SLOT,
    output logic              boot_req,
    output logic [SLOT_W-1:0] boot_slot,
    input  logic              boot_ack,
    input  logic              config_done,
    output logic              FABRIC_RESET,
    output logic              busy,
    output logic              error,
    output logic [SLOT_W-1:0] last_slot
);
    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, RESET_CYCLES, RELEASE_CYCLES) + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SET_W = $clog2(SYNC_STAGES + 1);
    localparam logic [TMR_W-1:0]  TMR_MAX   = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [SET_W-1:0]  SET_MAX   = SET_W'(SYNC_STAGES);
    localparam logic [SLOT_W:0]   SLOT_LIM  = (SLOT_W + 1)'(NUM_SLOTS);

    logic              w_boot_s;
    logic [SLOT_W-1:0] w_slot_s;
    logic              w_live, w_rise, w_cnt_zero, w_slot_ok, w_accept, w_timeout;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [TMR_W-1:0]  w_tmr_nxt;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [TMR_W-1:0]  r_tmr;
    logic [SET_W-1:0]  r_settle;
    logic              r_prev, r_armed, r_error, r_req, r_fr, r_busy;
    logic [SLOT_W-1:0] r_slot, r_last;

    warmboot_sync #(.STAGES(SYNC_STAGES)) u_sync_boot (
        .i_clk(CLK), .i_rst(RST), .i_d(BOOT), .o_q(w_boot_s)
    );
    for (genvar i = 0; i < SLOT_W; i++) begin : g_slot
        warmboot_sync #(.STAGES(SYNC_STAGES)) u_sync_slot (
            .i_clk(CLK), .i_rst(RST), .i_d(SLOT[i]), .o_q(w_slot_s[i])
        );
    end

    // The chain holds reset zeros until filled; a BOOT already high at reset release must not look like an edge.
    assign w_live     = r_settle == SET_MAX;
    assign w_rise     = w_live & w_boot_s & ~r_prev;
    assign w_cnt_zero = r_cnt == '0;
    assign w_slot_ok  = {1'b0, w_slot_s} < SLOT_LIM;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_zero ? r_cnt : r_cnt - 1'b1;
        w_tmr_nxt   = (r_tmr == TMR_MAX) ? r_tmr : r_tmr + 1'b1;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: if (w_rise && r_armed) begin
                w_state_nxt = S_DEBOUNCE;
                w_cnt_nxt   = CNT_W'(DEBOUNCE_CYCLES - 1);
            end
            S_DEBOUNCE: if (!w_boot_s) w_state_nxt = S_IDLE;
            else if (w_cnt_zero) begin
                w_accept    = 1'b1;
                w_state_nxt = w_slot_ok ? S_ASSERT : S_IDLE;
                w_cnt_nxt   = CNT_W'(RESET_CYCLES - 1);
            end
            S_ASSERT: if (w_cnt_zero) w_state_nxt = S_REQUEST;
            S_REQUEST: if (boot_ack) begin
                w_state_nxt = config_done ? S_RELEASE : S_WAIT_DONE;
                w_tmr_nxt   = '0;
                w_cnt_nxt   = CNT_W'(RELEASE_CYCLES - 1);
            end
            S_WAIT_DONE: if (config_done || r_tmr == TMR_MAX) begin
                w_state_nxt = S_RELEASE;
                w_timeout   = !config_done;
                w_cnt_nxt   = CNT_W'(RELEASE_CYCLES - 1);
            end
            S_RELEASE: if (w_cnt_zero) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_tmr    <= '0;
            r_settle <= '0;
            r_prev   <= 1'b1;
            r_armed  <= 1'b1;
            r_slot   <= '0;
            r_last   <= '0;
            r_error  <= 1'b0;
            r_req    <= 1'b0;
            r_fr     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_tmr    <= w_tmr_nxt;
            r_settle <= w_live ? r_settle : r_settle + 1'b1;
            r_prev   <= w_live ? w_boot_s : 1'b1;
            r_armed  <= w_accept ? 1'b0 : (r_state == S_IDLE && w_live && !w_boot_s) ? 1'b1 : r_armed;
            if (w_accept) begin
                r_slot  <= w_slot_s;
                r_error <= !w_slot_ok;
            end else if (w_timeout) r_error <= 1'b1;
            // In RELEASE the error flag can only have been set by a timeout, so clear means success.
            if (r_state == S_RELEASE && w_cnt_zero && !r_error) r_last <= r_slot;
            r_req    <= w_state_nxt == S_REQUEST;
            r_fr     <= w_state_nxt inside {S_ASSERT, S_REQUEST, S_WAIT_DONE, S_RELEASE};
            r_busy   <= w_state_nxt != S_IDLE;
        end
    end

    assign boot_req     = r_req;
    assign boot_slot    = r_slot;
    assign FABRIC_RESET = r_fr;
    assign busy         = r_busy;
    assign error        = r_error;
    assign last_slot    = r_last;
endmodule

// File: tb/tb_warmboot_sequencer.sv
// tb_warmboot_sequencer: directed and randomized boots checked every cycle against
// a timestamp-based behavioural model, plus hand-computed literal expectations.
module tb_warmboot_sequencer;
    localparam int N   = 2;
    localparam int D   = 4;
    localparam int R   = 16;
    localparam int REL = 8;
    localparam int T   = 100;
    localparam int NS  = 8;
    localparam int INF = 1 << 30;

    logic       CLK = 1'b0, RST = 1'b1, BOOT = 1'b0, boot_ack = 1'b0, config_done = 1'b0;
    logic [3:0] SLOT = 4'd0;
    logic       boot_req, FABRIC_RESET, busy, error;
    logic [3:0] boot_slot, last_slot;

    int n_vec = 0;
    int n_err = 0;

    warmboot_sequencer #(
        .SYNC_STAGES(N), .DEBOUNCE_CYCLES(D), .RESET_CYCLES(R),
        .RELEASE_CYCLES(REL), .TIMEOUT_CYCLES(T), .NUM_SLOTS(NS)
    ) dut (
        .CLK(CLK), .RST(RST), .BOOT(BOOT), .SLOT(SLOT),
        .boot_req(boot_req), .boot_slot(boot_slot), .boot_ack(boot_ack),
        .config_done(config_done), .FABRIC_RESET(FABRIC_RESET), .busy(busy),
        .error(error), .last_slot(last_slot)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 qualifying trigger, 2 boot in progress;
    // the boot itself is described by edge timestamps (accept, ack, release start).
    bit         bq[$];
    logic [3:0] sq[$];
    bit         prev_sb = 1'b1, armed = 1'b1, m_err = 1'b0, live, sb, rise;
    logic [3:0] m_slot = 4'd0, m_last = 4'd0;
    int         t = 0, mode = 0, rstart = 0, a = INF, ack_e = INF, rel_s = INF;

    initial forever begin
        @(posedge CLK);
        if (RST) begin
            bq.delete();
            sq.delete();
            prev_sb = 1'b1; armed = 1'b1; m_err = 1'b0; m_slot = 4'd0; m_last = 4'd0;
            t = 0; mode = 0; a = INF; ack_e = INF; rel_s = INF;
        end else begin
            t++;
            bq.push_back(BOOT);
            sq.push_back(SLOT);
            if (bq.size() > N + 1) begin
                void'(bq.pop_front());
                void'(sq.pop_front());
            end
            live = bq.size() == N + 1;
            sb   = live && bq[0];
            rise = sb && !prev_sb;
            if (mode == 0) begin
                if (live && !sb) armed = 1'b1;
                else if (rise && armed) begin
                    mode = 1;
                    rstart = t;
                end
            end else if (mode == 1) begin
                if (!sb) mode = 0;
                else if (t - rstart == D) begin
                    armed  = 1'b0;
                    m_slot = sq[0];
                    m_err  = sq[0] >= NS;
                    mode   = m_err ? 0 : 2;
                    a = t; ack_e = INF; rel_s = INF;
                end
            end else begin
                if (ack_e == INF) begin
                    if (t > a + R && boot_ack) begin
                        ack_e = t;
                        if (config_done) rel_s = t;
                    end
                end else if (rel_s == INF) begin
                    if (config_done) rel_s = t;
                    else if (t == ack_e + T + 1) begin
                        m_err = 1'b1;
                        rel_s = t;
                    end
                end else if (t == rel_s + REL) begin
                    mode = 0;
                    if (!m_err) m_last = m_slot;
                end
            end
            prev_sb = live ? sb : 1'b1;
        end
    end

    initial forever begin
        @(negedge CLK);
        if (RST) begin
            chk("rst_boot_req", boot_req, 0);
            chk("rst_fabric_reset", FABRIC_RESET, 0);
            chk("rst_busy", busy, 0);
            chk("rst_error", error, 0);
            chk("rst_last_slot", last_slot, 0);
        end else begin
            chk("boot_req", boot_req, (mode == 2) && (t >= a + R) && (ack_e == INF));
            chk("fabric_reset", FABRIC_RESET, mode == 2);
            chk("busy", busy, mode != 0);
            chk("error", error, m_err);
            chk("boot_slot", boot_slot, m_slot);
            chk("last_slot", last_slot, m_last);
        end
    end

    typedef struct {
        int fr_first, fr_cnt, fr_rises, req_cnt, busy_cnt, err_rise;
        logic [3:0] req_slot;
    } res_t;

    task automatic run_boot(input int blen, input int slot, input int ack_dly, input int done_dly,
                            input bit spur, output res_t r);
        int  req_rise = 0;
        bit  prev_fr = 1'b0, prev_err = error, fin = 1'b0;
        r = '{0, 0, 0, 0, 0, 0, 4'd0};
        SLOT = 4'(slot);
        for (int c = 1; c <= 400; c++) begin
            BOOT        = c <= blen;
            boot_ack    = (req_rise != 0 && c == req_rise + ack_dly) || (spur && c == 5);
            config_done = (done_dly >= 0 && req_rise != 0 && c == req_rise + ack_dly + done_dly) || (spur && c == 10);
            @(negedge CLK);
            if (FABRIC_RESET) begin
                r.fr_cnt++;
                if (!prev_fr) r.fr_rises++;
                if (r.fr_first == 0) r.fr_first = c;
            end
            prev_fr = FABRIC_RESET;
            if (boot_req) begin
                r.req_cnt++;
                if (req_rise == 0) begin
                    req_rise   = c;
                    r.req_slot = boot_slot;
                end
            end
            if (busy) r.busy_cnt++;
            if (error && !prev_err && r.err_rise == 0) r.err_rise = c;
            prev_err = error;
            if (!busy && c > blen + N + D + 2) begin
                fin = 1'b1;
                break;
            end
        end
        BOOT = 1'b0;
        boot_ack = 1'b0;
        config_done = 1'b0;
        chk("run_completes", fin, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        res_t r;
        int   bcnt;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (6) @(negedge CLK);

        // 1: nominal boot; latency 2+4+1, FR = 16 + 3 req + 20 wait + 8 release = 47
        run_boot(10, 5, 3, 20, 0, r);
        chk("t1_latency", r.fr_first, 7);
        chk("t1_fr_cycles", r.fr_cnt, 47);
        chk("t1_req_cycles", r.req_cnt, 3);
        chk("t1_req_slot", r.req_slot, 5);
        chk("t1_error", error, 0);
        chk("t1_last_slot", last_slot, 5);

        // 2: glitch too short to qualify
        run_boot(3, 5, 3, 20, 0, r);
        chk("t2_fr_cycles", r.fr_cnt, 0);
        chk("t2_busy_cycles", r.busy_cnt, 3);
        chk("t2_error", error, 0);

        // 3: slot out of range
        run_boot(10, 15, 3, 20, 0, r);
        chk("t3_error", error, 1);
        chk("t3_fr_cycles", r.fr_cnt, 0);
        chk("t3_busy_cycles", r.busy_cnt, 4);
        chk("t3_last_slot", last_slot, 5);

        // 4: no config_done; ack at edge 25, timeout at 25+101, release 8 later
        run_boot(10, 3, 2, -1, 0, r);
        chk("t4_latency", r.fr_first, 7);
        chk("t4_err_rise", r.err_rise, 126);
        chk("t4_fr_cycles", r.fr_cnt, 127);
        chk("t4_error", error, 1);
        chk("t4_last_slot", last_slot, 5);

        // 6: ack and done together
        run_boot(10, 6, 2, 0, 0, r);
        chk("t6_fr_cycles", r.fr_cnt, 26);
        chk("t6_req_cycles", r.req_cnt, 2);
        chk("t6_error", error, 0);
        chk("t6_last_slot", last_slot, 6);

        // BOOT held high through a whole boot never retriggers
        run_boot(120, 4, 1, 3, 1, r);
        chk("hold_fr_rises", r.fr_rises, 1);
        chk("hold_last_slot", last_slot, 4);

        // 5: reset during WAIT_DONE with BOOT still high
        BOOT = 1'b1;
        SLOT = 4'd2;
        for (int i = 0; i < 60 && !boot_req; i++) @(negedge CLK);
        chk("t5_req_seen", boot_req, 1);
        boot_ack = 1'b1;
        @(negedge CLK);
        boot_ack = 1'b0;
        repeat (5) @(negedge CLK);
        chk("t5_in_wait", FABRIC_RESET, 1);
        #2 RST = 1'b1;
        #1;
        chk("t5_rst_fr", FABRIC_RESET, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_req", boot_req, 0);
        chk("t5_rst_last", last_slot, 0);
        chk("t5_rst_slot", boot_slot, 0);
        @(negedge CLK);
        RST = 1'b0;
        bcnt = 0;
        repeat (40) begin
            @(negedge CLK);
            if (busy) bcnt++;
        end
        chk("t5_no_retrigger", bcnt, 0);
        BOOT = 1'b0;
        repeat (4) @(negedge CLK);
        run_boot(10, 2, 1, 5, 0, r);
        chk("t5_rearm_latency", r.fr_first, 7);
        chk("t5_rearm_last", last_slot, 2);

        // randomized boots, checked cycle by cycle against the model
        for (int k = 0; k < 30; k++) begin
            run_boot($urandom_range(1, 12), $urandom_range(0, 15), $urandom_range(1, 6),
                     ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 30), 1'($urandom_range(0, 1)), r);
            repeat ($urandom_range(0, 5)) @(negedge CLK);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
